// File: rtl/pipelined_adder_rv.sv
// Pipelined adder with the carry chain split into STAGES slices, valid/ready backpressure and flush.
// Optional subtract mode is enabled by defining PIPELINED_ADDER_RV_SUB_EN.
module pipelined_adder_rv #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PIPELINED_ADDER_RV_SUB_EN
    input  logic             in_sub,
`endif
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0) begin : g_bad_width
        $error("pipelined_adder_rv: WIDTH must be divisible by STAGES");
    end
    if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
        $error("pipelined_adder_rv: STAGES must be in 1..8");
    end

    logic [STAGES-1:0]             v_q, v_d, adv;
    logic [STAGES-1:0]             c_q, c_d;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, r_q, r_d;

    // Per-stage view of the upstream transaction (primary inputs for stage 0).
    logic [STAGES-1:0]             up_v, up_c;
    logic [STAGES-1:0][WIDTH-1:0]  up_a, up_b, up_r;
    logic [STAGES-1:0][CHUNK:0]    slice_sum;

    logic             sub_mode;
`ifdef PIPELINED_ADDER_RV_SUB_EN
    assign sub_mode = in_sub;
`else
    assign sub_mode = 1'b0;
`endif

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign up_v[g] = in_valid;
            assign up_a[g] = a;
            // Subtraction is folded in up front: ~b with carry-in 1 travels as plain data.
            assign up_b[g] = sub_mode ? ~b : b;
            assign up_c[g] = sub_mode;
            assign up_r[g] = '0;
        end else begin : g_rest
            assign up_v[g] = v_q[g-1];
            assign up_a[g] = a_q[g-1];
            assign up_b[g] = b_q[g-1];
            assign up_c[g] = c_q[g-1];
            assign up_r[g] = r_q[g-1];
        end
        // Stage g can move iff some stage at or after it is empty, or the sink accepts.
        assign adv[g] = out_ready | ~(&v_q[STAGES-1:g]);
        assign slice_sum[g] = {1'b0, up_a[g][g*CHUNK +: CHUNK]}
                            + {1'b0, up_b[g][g*CHUNK +: CHUNK]}
                            + {{CHUNK{1'b0}}, up_c[g]};
    end

    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign sum       = r_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    always_comb begin
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        r_d = r_q;
        for (int i = 0; i < STAGES; i++) begin
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (adv[i]) begin
                v_d[i] = up_v[i];
            end
            if (adv[i] && up_v[i]) begin
                a_d[i]                   = up_a[i];
                b_d[i]                   = up_b[i];
                r_d[i]                   = up_r[i];
                r_d[i][i*CHUNK +: CHUNK] = slice_sum[i][CHUNK-1:0];
                c_d[i]                   = slice_sum[i][CHUNK];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        r_q <= r_d;
        c_q <= c_d;
    end

    // Operands held in the final stage have no consumer.
    logic unused_last_operands;
    assign unused_last_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_adder_rv.sv
// Directed self-checking bench for pipelined_adder_rv (WIDTH=32, STAGES=4).
module tb_pipelined_adder_rv;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef PIPELINED_ADDER_RV_SUB_EN
    logic         in_sub = 1'b0;
`endif
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_adder_rv #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef PIPELINED_ADDER_RV_SUB_EN
        .in_sub    (in_sub),
`endif
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction; checks exact latency and the result.
    task automatic send_one(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub,
                            input logic [W-1:0] esum, input logic ecout, input string name);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
`ifdef PIPELINED_ADDER_RV_SUB_EN
        in_sub = vsub;
`endif
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready);
        end
        for (int cyc = 1; cyc <= S; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            #1;
            if (cyc < S) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++; $display("FAIL %s_early_valid cyc=%0d got=%b want=0", name, cyc, out_valid);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || sum !== esum || cout !== ecout) begin
                    failures++;
                    $display("FAIL %s got valid=%b sum=%h cout=%b want valid=1 sum=%h cout=%b",
                             name, out_valid, sum, cout, esum, ecout);
                end
            end
        end
`ifndef PIPELINED_ADDER_RV_SUB_EN
        if (vsub) $display("note: subtract vector %s run as add build", name);
`endif
    endtask

    task automatic test_add();
        send_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "add_chunk_carry");
        send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "add_wrap");
        send_one(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, "add_msb");
        send_one(32'h1234_5678, 32'h0FED_CBA8, 1'b0, 32'h2222_2220, 1'b0, "add_ripple");
        send_one(32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, "add_two_carries");
    endtask

    // Inputs k=1..8 on consecutive cycles; beat k must appear at negedge k-1+S.
    task automatic test_back_to_back();
        int beats = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 8 + S + 2; t++) begin
            @(negedge clk);
            if (t < 8) begin
                in_valid = 1'b1; a = 32'(t + 1); b = 32'(t + 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL b2b_in_ready t=%0d got=%b want=1", t, in_ready);
                end
            end
            checks++;
            if (out_valid !== ((t >= S) && (t < S + 8))) begin
                failures++; $display("FAIL b2b_valid t=%0d got=%b want=%b", t, out_valid,
                                     ((t >= S) && (t < S + 8)));
            end else if (out_valid) begin
                beats++;
                checks++;
                if (sum !== 32'(2 * (t - S + 1)) || cout !== 1'b0) begin
                    failures++; $display("FAIL b2b_sum t=%0d got=%h/%b want=%h/0", t, sum, cout,
                                         32'(2 * (t - S + 1)));
                end
            end
        end
        checks++;
        if (beats != 8) begin
            failures++; $display("FAIL b2b_beats got=%0d want=8", beats);
        end
    endtask

    // Fill with out_ready=0, hold 3 cycles, release; scoreboard checks order and count.
    task automatic test_stall();
        logic [W:0] exp_q[$];
        logic [W:0] front;
        int sent = 0;
        int got = 0;
        for (int t = 0; t < 40 && !(sent == 6 && got == 6); t++) begin
            @(negedge clk);
            out_ready = (t >= 7);
            in_valid = (sent < 6);
            a = 32'hFFFF_FFF0 + 32'(sent);
            b = 32'(sent);
            #1;
            if (t < 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++; $display("FAIL stall_fill_ready t=%0d got=%b want=1", t, in_ready);
                end
            end else if (t < 7) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 32'hFFFF_FFF0) begin
                    failures++;
                    $display("FAIL stall_hold t=%0d got ready=%b valid=%b sum=%h want 0/1/fffffff0",
                             t, in_ready, out_valid, sum);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stall_extra_beat got=%h want none", sum);
                end else begin
                    front = exp_q.pop_front();
                    if ({cout, sum} !== front) begin
                        failures++; $display("FAIL stall_order got=%h want=%h", {cout, sum}, front);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (got != 6 || sent != 6 || out_valid !== 1'b0) begin
            failures++; $display("FAIL stall_drain got sent=%0d beats=%0d valid=%b want 6/6/0",
                                 sent, got, out_valid);
        end
    endtask

    task automatic expect_quiet(input string name);
        for (int t = 0; t < S + 1; t++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL %s t=%0d got valid=%b want=0", name, t, out_valid);
            end
        end
    endtask

    task automatic test_flush();
        // Three stages valid, sink blocked, then flush with an input on offer.
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(100 + t); b = 32'd1;
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; a = 32'h5555_5555; b = 32'h1111_1111;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush3_ready got ready=%b valid=%b want 0/0", in_ready, out_valid);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush3_next got valid=%b want=0", out_valid);
        end
        expect_quiet("flush3_quiet");

        // Full pipeline, flush together with an output handshake.
        out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(200 + t); b = 32'd2;
        end
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a = 32'd9; b = 32'd9;
        #1;
        checks++;
        if (out_valid !== 1'b1 || sum !== 32'd202 || in_ready !== 1'b0) begin
            failures++; $display("FAIL flush4_beat got valid=%b sum=%h ready=%b want 1/000000ca/0",
                                 out_valid, sum, in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        expect_quiet("flush4_quiet");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(300 + t); b = 32'd3;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL midreset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("midreset_quiet");
    endtask

`ifdef PIPELINED_ADDER_RV_SUB_EN
    task automatic test_sub();
        logic [W-1:0] ea[4] = '{32'd10, 32'd10, 32'd3, 32'd1};
        logic [W-1:0] eb[4] = '{32'd3, 32'd3, 32'd10, 32'd1};
        logic         es[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] er[4] = '{32'd13, 32'd7, 32'hFFFF_FFF9, 32'd2};
        logic         ec[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        send_one(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
        send_one(32'd7, 32'd5, 1'b1, 32'd2, 1'b1, "sub_noborrow");
        out_ready = 1'b1;
        for (int t = 0; t < 4 + S; t++) begin
            @(negedge clk);
            if (t < 4) begin
                in_valid = 1'b1; a = ea[t]; b = eb[t]; in_sub = es[t];
            end else begin
                in_valid = 1'b0; in_sub = 1'b0;
            end
            #1;
            if (t >= S) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== er[t-S] || cout !== ec[t-S]) begin
                    failures++; $display("FAIL sub_mixed beat=%0d got %b/%h/%b want 1/%h/%b", t - S,
                                         out_valid, sum, cout, er[t-S], ec[t-S]);
                end
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
`ifdef PIPELINED_ADDER_RV_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
